sram_pingpong_writer: RTL

SRAM_PINGPONG_WRITER -- requirements
Module: sram_pingpong_writer

---
 rtl/sram_ctrl_pkg.sv | 35 +++
 rtl/sram_pingpong_writer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM ping-pong capture writer:
// controller states and the bit layout of the sram_flag status word.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int FLAG_W      = 6;
    localparam int FLAG_FULL0  = 0;
    localparam int FLAG_FULL1  = 1;
    localparam int FLAG_OVF    = 2;
    localparam int FLAG_ACTIVE = 3;
    localparam int FLAG_SEQ_LO = 4;
    localparam int FLAG_SEQ_HI = 5;

    function automatic logic [FLAG_W-1:0] pack_flag(
        input logic [1:0] full,
        input logic       ovf,
        input logic       active,
        input logic [1:0] seq
    );
        logic [FLAG_W-1:0] f;
        f                          = '0;
        f[FLAG_FULL0]              = full[0];
        f[FLAG_FULL1]              = full[1];
        f[FLAG_OVF]                = ovf;
        f[FLAG_ACTIVE]             = active;
        f[FLAG_SEQ_HI:FLAG_SEQ_LO] = seq;
        return f;
    endfunction

endpackage

// File: rtl/sram_pingpong_writer.sv
// Streams LVDS words into two alternating SRAM banks; the HPS releases a bank
// once it has read it, and words arriving while both banks are full are dropped.
module sram_pingpong_writer
    import sram_ctrl_pkg::*;
#(
    parameter int BANK_WORDS = 8192,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    input  logic [1:0]        bank_release,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_clken,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    output logic [3:0]        sram_byteenable,
    output logic [5:0]        sram_flag
);

    localparam int OFF_W = ADDR_W - 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_en_d;
    logic               r_bank;
    logic [OFF_W-1:0]   r_offset;
    logic [1:0]         r_full;
    logic               r_ovf;
    logic [1:0]         r_seq;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_wr;

    logic               w_en_rise;
    logic               w_other;
    logic               w_last;
    logic               w_accept;
    logic               w_drop;
    logic [1:0]         w_full_next;
    logic [FLAG_W-1:0]  w_flag;

    assign w_en_rise = en & ~r_en_d;
    assign w_other   = ~r_bank;
    assign w_last    = (r_offset == OFF_W'(BANK_WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a bank landing on a still-full partner parks in WAIT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_en_rise) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept && w_last && r_full[w_other] && !bank_release[w_other]) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end else if (bank_release[r_bank] && r_full[r_bank]) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output / qualifier logic; completing a bank overrides a same-cycle release
    always_comb begin
        w_accept    = (r_state == ST_FILL) && s_valid;
        w_drop      = (r_state == ST_WAIT) && s_valid;
        w_full_next = r_full;
        for (int unsigned b = 0; b < 2; b++) begin
            if (w_accept && w_last && (r_bank == b[0])) begin
                w_full_next[b] = 1'b1;
            end else if (bank_release[b] && r_full[b]) begin
                w_full_next[b] = 1'b0;
            end
        end
        w_flag = pack_flag(r_full, r_ovf, (r_state != ST_IDLE), r_seq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_d   <= 1'b0;
            r_bank   <= 1'b0;
            r_offset <= '0;
            r_full   <= '0;
            r_ovf    <= 1'b0;
            r_seq    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_en_d <= en;
            r_wr   <= w_accept;
            if (w_accept) begin
                r_addr  <= {r_bank, r_offset};
                r_wdata <= s_data;
            end
            if ((r_state == ST_IDLE) && w_en_rise) begin
                r_full   <= '0;
                r_ovf    <= 1'b0;
                r_seq    <= '0;
                r_bank   <= 1'b0;
                r_offset <= '0;
            end else begin
                r_full <= w_full_next;
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                if (w_accept) begin
                    if (w_last) begin
                        r_offset <= '0;
                        r_bank   <= w_other;
                        r_seq    <= r_seq + 2'd1;
                    end else begin
                        r_offset <= r_offset + 1'b1;
                    end
                end
            end
        end
    end

    assign sram_address    = r_addr;
    assign sram_writedata  = r_wdata;
    assign sram_write      = r_wr;
    assign sram_chipselect = r_wr;
    assign sram_clken      = r_wr;
    assign sram_byteenable = {4{r_wr}};
    assign sram_flag       = w_flag;

endmodule
